// File: rtl/bist_fail_log.sv
// Result stage for the March BIST: saturating fail count, registered GoNoGo flag and,
// with BIST_FAIL_DIAG_EN defined, a show-ahead FIFO logging failing entries.
module bist_fail_log #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Done,
    input  logic             FailValid,
    input  logic [7:0]       FailAddr,
    input  logic [3:0]       FailExp,
    input  logic [3:0]       FailAct,
    input  logic [2:0]       FailElem,
    input  logic             RdEn,
    output logic             RdValid,
    output logic [18:0]      RdData,
    output logic [CNT_W-1:0] FailCount,
    output logic             Overflow,
    output logic             Busy,
    output logic             GoNoGo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             go;
    logic             fail_acc;

    // Start takes priority, so a same-cycle fail is never counted.
    assign fail_acc = (state == RUN) && FailValid && !Start;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= IDLE;
            count <= '0;
            go    <= 1'b0;
        end else if (Start) begin
            state <= RUN;
            count <= '0;
            go    <= 1'b0;
        end else if (state == RUN) begin
            if (FailValid && (count != '1))
                count <= count + CNT_W'(1);
            if (Done) begin
                state <= DONE;
                go    <= (count == '0) && !FailValid;
            end
        end
    end

    assign FailCount = count;
    assign Busy      = (state == RUN);
    assign GoNoGo    = go;

`ifdef BIST_FAIL_DIAG_EN
    localparam int AW = $clog2(DEPTH);

    logic [18:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        ovf;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = RdEn && !empty && !Start;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = fail_acc && (!full || pop);

    always_ff @(posedge Clock) begin
        if (!Reset_n || Start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (fail_acc && !push)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {FailElem, FailAddr, FailExp, FailAct};
    end

    assign RdValid  = !empty;
    assign RdData   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign Overflow = ovf;
`else
    logic unused_diag;
    assign unused_diag = ^{RdEn, FailAddr, FailExp, FailAct, FailElem, fail_acc};

    assign RdValid  = 1'b0;
    assign RdData   = '0;
    assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bist_fail_log.sv
// Directed bench for bist_fail_log (DEPTH=8, CNT_W=4); FIFO expectations follow BIST_FAIL_DIAG_EN.
module tb_bist_fail_log;

`ifdef BIST_FAIL_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n, Start, Done, FailValid, RdEn;
    logic [7:0]  FailAddr;
    logic [3:0]  FailExp, FailAct;
    logic [2:0]  FailElem;
    logic        RdValid, Overflow, Busy, GoNoGo;
    logic [18:0] RdData;
    logic [3:0]  FailCount;

    int checks = 0;
    int errors = 0;

    bist_fail_log #(.DEPTH(8), .CNT_W(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Done(Done),
        .FailValid(FailValid), .FailAddr(FailAddr), .FailExp(FailExp),
        .FailAct(FailAct), .FailElem(FailElem), .RdEn(RdEn),
        .RdValid(RdValid), .RdData(RdData), .FailCount(FailCount),
        .Overflow(Overflow), .Busy(Busy), .GoNoGo(GoNoGo)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [18:0] ent(input logic [7:0] a, input logic [3:0] k);
        return {k[2:0], a, k, ~k};
    endfunction

    task automatic fail(input logic [7:0] a, input logic [3:0] k);
        FailValid = 1'b1;
        FailAddr  = a;
        FailElem  = k[2:0];
        FailExp   = k;
        FailAct   = ~k;
        tick();
        FailValid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1; tick(); Start = 1'b0;
    endtask

    task automatic pulse_done();
        Done = 1'b1; tick(); Done = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [18:0] e);
        check({tag, "_valid"}, 32'(RdValid), 32'(DIAG));
        check({tag, "_data"}, 32'(RdData), DIAG ? 32'(e) : 32'd0);
        RdEn = 1'b1; tick(); RdEn = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdvalid"}, 32'(RdValid), 0);
        check({tag, "_rddata"}, 32'(RdData), 0);
        check({tag, "_count"}, 32'(FailCount), 0);
        check({tag, "_ovf"}, 32'(Overflow), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_gonogo"}, 32'(GoNoGo), 0);
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Done = 1'b0; FailValid = 1'b0; RdEn = 1'b0;
        FailAddr = '0; FailExp = '0; FailAct = '0; FailElem = '0;
        tick(); tick();
        check_reset_values("reset");
        Reset_n = 1'b1;
        tick();

        // Clean run
        pulse_start();
        check("clean_busy", 32'(Busy), 1);
        for (int i = 0; i < 100; i++) tick();
        pulse_done();
        check("clean_busy_done", 32'(Busy), 0);
        check("clean_gonogo", 32'(GoNoGo), 1);
        check("clean_count", 32'(FailCount), 0);
        check("clean_rdvalid", 32'(RdValid), 0);

        // Three fails
        pulse_start();
        check("three_gonogo_cleared", 32'(GoNoGo), 0);
        fail(8'h05, 4'd1);
        check("three_first_visible", 32'(RdValid), 32'(DIAG));
        fail(8'h80, 4'd3);
        fail(8'hFF, 4'd5);
        pulse_done();
        check("three_gonogo", 32'(GoNoGo), 0);
        check("three_count", 32'(FailCount), 3);
        pop_expect("three_e0", ent(8'h05, 4'd1));
        pop_expect("three_e1", ent(8'h80, 4'd3));
        pop_expect("three_e2", ent(8'hFF, 4'd5));
        check("three_empty", 32'(RdValid), 0);
        RdEn = 1'b1; tick(); RdEn = 1'b0;
        check("pop_empty_valid", 32'(RdValid), 0);
        check("pop_empty_data", 32'(RdData), 0);

        // Full FIFO with simultaneous push and pop
        pulse_start();
        for (int i = 0; i < 8; i++) fail(i[7:0], i[3:0]);
        check("full_ovf", 32'(Overflow), 0);
        RdEn = 1'b1;
        fail(8'h40, 4'd9);
        RdEn = 1'b0;
        check("pushpop_ovf", 32'(Overflow), 0);
        check("pushpop_count", 32'(FailCount), 9);
        pulse_done();
        for (int i = 1; i < 8; i++) pop_expect($sformatf("pushpop_e%0d", i), ent(i[7:0], i[3:0]));
        pop_expect("pushpop_e8", ent(8'h40, 4'd9));
        check("pushpop_empty", 32'(RdValid), 0);

        // Overflow: 10 back-to-back fails
        pulse_start();
        FailValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            FailAddr = 8'h10 + i[7:0]; FailElem = i[2:0]; FailExp = i[3:0]; FailAct = ~i[3:0];
            tick();
        end
        FailValid = 1'b0;
        pulse_done();
        check("ovf_count", 32'(FailCount), 10);
        check("ovf_flag", 32'(Overflow), 32'(DIAG));
        for (int i = 0; i < 8; i++) pop_expect($sformatf("ovf_e%0d", i), ent(8'h10 + i[7:0], i[3:0]));
        check("ovf_empty", 32'(RdValid), 0);
        check("ovf_sticky", 32'(Overflow), 32'(DIAG));

        // Start with same-cycle fail: fail dropped, log cleared
        Start = 1'b1; FailValid = 1'b1; FailAddr = 8'h33;
        tick();
        Start = 1'b0; FailValid = 1'b0;
        check("startfail_count", 32'(FailCount), 0);
        check("startfail_rdvalid", 32'(RdValid), 0);
        check("startfail_ovf", 32'(Overflow), 0);
        // Done with the only fail
        Done = 1'b1;
        fail(8'h21, 4'd6);
        Done = 1'b0;
        check("donefail_count", 32'(FailCount), 1);
        check("donefail_gonogo", 32'(GoNoGo), 0);
        check("donefail_busy", 32'(Busy), 0);
        // Fail in DONE is ignored
        fail(8'h22, 4'd7);
        check("donestate_count", 32'(FailCount), 1);
        pop_expect("donefail_e0", ent(8'h21, 4'd6));
        check("donestate_empty", 32'(RdValid), 0);

        // Reset mid-RUN with 4 entries
        pulse_start();
        for (int i = 0; i < 4; i++) fail(8'hA0 + i[7:0], i[3:0]);
        check("prereset_count", 32'(FailCount), 4);
        Reset_n = 1'b0; tick(); Reset_n = 1'b1;
        check_reset_values("midreset");
        tick();
        check("midreset_idle_busy", 32'(Busy), 0);

        // Restart after a failing run
        pulse_start();
        fail(8'h01, 4'd2);
        fail(8'h02, 4'd3);
        pulse_done();
        check("fail_run_gonogo", 32'(GoNoGo), 0);
        check("fail_run_count", 32'(FailCount), 2);
        pulse_start();
        check("restart_gonogo", 32'(GoNoGo), 0);
        check("restart_count", 32'(FailCount), 0);
        check("restart_rdvalid", 32'(RdValid), 0);
        for (int i = 0; i < 5; i++) tick();
        check("restart_gonogo_run", 32'(GoNoGo), 0);
        pulse_done();
        check("restart_gonogo_done", 32'(GoNoGo), 1);

        // Saturation at 4 bits
        pulse_start();
        for (int i = 0; i < 20; i++) fail(i[7:0], i[3:0]);
        check("sat_count", 32'(FailCount), 15);
        pulse_done();
        check("sat_gonogo", 32'(GoNoGo), 0);
        check("sat_ovf", 32'(Overflow), 32'(DIAG));
        check("sat_rdvalid", 32'(RdValid), 32'(DIAG));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_fail_log.md
# bist_fail_log

- Downstream result stage for the March BIST of the 256x4b SRAM.
- Consumes the per-cycle compare-fail strobe from the March engine and keeps a saturating fail count.
- Logs failing address, expected/actual data and March element into a small FIFO.
- Drives the registered pass/fail flag `GoNoGo` that the top level and the bench observe.
- Failing entries are read out through a show-ahead valid/enable port for diagnosis.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, 2..64.
- `CNT_W`, 16: fail-count width; the count saturates at all-ones.
- `Clock` in 1: single clock, rising edge.
- `Reset_n` in 1: reset, synchronous, active-low.
- `Start` in 1: pulse at BIST start; clears the log and enters RUN.
- `Done` in 1: pulse at BIST end; freezes the log.
- `FailValid` in 1: compare miss this cycle.
- `FailAddr` in 8: failing SRAM address.
- `FailExp` in 4: expected data.
- `FailAct` in 4: read data.
- `FailElem` in 3: March element index, 0..7.
- `RdEn` in 1: pop the head entry; ignored when `RdValid`=0.
- `RdValid` out 1: FIFO not empty.
- `RdData` out 19: head entry, packed as {`FailElem`,`FailAddr`,`FailExp`,`FailAct`}.
- `FailCount` out CNT_W: total fails since `Start`, saturating.
- `Overflow` out 1: sticky; at least one fail entry was dropped.
- `Busy` out 1: state is RUN.
- `GoNoGo` out 1: 1 = pass; valid in DONE only.

## Operation
- FSM states and transitions:
  - IDLE: `Start` → RUN.
  - RUN: `Start` → RUN (re-clear); `Done` → DONE.
  - DONE: `Start` → RUN. `Done` outside RUN is ignored.
- `Start` (any state):
  - Clears FIFO pointers, `FailCount` and `Overflow`.
  - `Start` wins over a same-cycle `FailValid` or `RdEn`; both are dropped.
- Fail handling in RUN only; `FailValid` in IDLE or DONE is ignored.
- Per `FailValid`:
  - `FailCount` increments and saturates at 2^CNT_W−1.
  - Entry is pushed if the FIFO is not full, or is full with a same-cycle accepted pop.
  - Otherwise the entry is dropped and `Overflow` is set; the count still increments.
- `Done` with `FailValid` in the same cycle: the fail is logged and counted, then the FSM enters DONE.
- Reads are allowed in every state, so draining continues in DONE.
- Pop while empty: no effect.
- Push into an empty FIFO: not visible until the next cycle (no fall-through).
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full = MSBs differ and the rest are equal.
- `GoNoGo` register:
  - Cleared on `Start` and on reset.
  - Loaded with (count==0, including a same-cycle final fail) on the RUN→DONE transition.
  - Held until the next `Start`.

## Timing
- Reset values: state IDLE, `RdValid` 0, `RdData` 0, `FailCount` 0, `Overflow` 0, `Busy` 0, `GoNoGo` 0.
- All outputs are registered or decoded from registers; there is no input-to-output combinational path.
- `FailValid` at edge N → `FailCount` and `RdValid` updated after edge N.
- `RdData` is the show-ahead head. `RdEn` at edge N → next entry (or `RdValid`=0) after edge N.
- `Done` at edge N → `Busy`=0 and `GoNoGo` valid after edge N.
- Back-to-back fails every cycle are sustained; throughput is 1 push and 1 pop per cycle.
- Reset mid-RUN: all state is lost and the block returns to IDLE.

## Configuration
- `BIST_FAIL_DIAG_EN` defined:
  - The FIFO, `RdData` packing and the `Overflow` logic are compiled in.
- `BIST_FAIL_DIAG_EN` undefined:
  - FIFO storage is removed.
  - `RdValid`, `RdData` and `Overflow` are tied to 0.
  - `RdEn`, `FailAddr`, `FailExp`, `FailAct` and `FailElem` are unused.
  - `FailCount`, `Busy` and `GoNoGo` behave identically to the defined build.

## Test plan
- Clean run:
  - Stimulus: reset, `Start`, 100 cycles without fails, `Done`.
  - Response: `GoNoGo`=1, `FailCount`=0, `RdValid`=0.
- Three fails:
  - Stimulus: fails at addr 0x05/0x80/0xFF with elem 1/3/5, then `Done`.
  - Response: `GoNoGo`=0, `FailCount`=3. Pops return entries in order, e.g. {1,0x05,exp,act}, then `RdValid`=0.
- Overflow with DEPTH=8:
  - Stimulus: 10 consecutive fails with no reads.
  - Response: `FailCount`=10, `Overflow`=1, 8 entries read (first 8 addresses).
  - Also: full FIFO with simultaneous push+pop gives no overflow and 8 entries remaining.
- Same-cycle events:
  - `Start` with `FailValid`: count 0.
  - `Done` with `FailValid` as the only fail: `FailCount`=1, `GoNoGo`=0.
  - `FailValid` in DONE: ignored.
- Reset and restart:
  - `Reset_n`=0 mid-RUN with 4 entries logged: all outputs return to reset values the next cycle.
  - Second `Start` after a failing run: `GoNoGo`=0 and `FailCount`=0 until the new `Done`.
- Saturation with CNT_W=4:
  - Stimulus: 20 fails.
  - Response: `FailCount`=15.
  - Build without `BIST_FAIL_DIAG_EN`: `RdValid` stays 0.
